// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: control and strobe bundle of the UART baud-rate tick generator.
//   master: drives div_en, sync, cfg_we, cfg_div_int, cfg_div_frac; observes the strobes.
//   slave : the generator; samples the controls, drives o_os_tick, o_bit_tick,
//           o_mid_tick, o_os_phase and o_cfg_err.
interface uart_baud_gen_if #(
    parameter int unsigned INT_W  = 20,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned OS     = 16
);
    localparam int unsigned PH_W = (OS > 1) ? $clog2(OS) : 1;

    logic              div_en;
    logic              sync;
    logic              cfg_we;
    logic [INT_W-1:0]  cfg_div_int;
    logic [FRAC_W-1:0] cfg_div_frac;
    logic              o_os_tick;
    logic              o_bit_tick;
    logic              o_mid_tick;
    logic [PH_W-1:0]   o_os_phase;
    logic              o_cfg_err;

    modport master (
        output div_en, sync, cfg_we, cfg_div_int, cfg_div_frac,
        input  o_os_tick, o_bit_tick, o_mid_tick, o_os_phase, o_cfg_err
    );

    modport slave (
        input  div_en, sync, cfg_we, cfg_div_int, cfg_div_frac,
        output o_os_tick, o_bit_tick, o_mid_tick, o_os_phase, o_cfg_err
    );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: baud-rate tick generator with integer + fractional divisor, oversample,
// bit and mid-bit strobes, and a phase-resync input.
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : uart_baud_gen_if.slave
//     div_en       run enable (low: counters held at zero, ticks suppressed)
//     sync         phase restart, e.g. RX start-bit edge
//     cfg_we       divisor write strobe; cfg_div_int must be >= 2
//     cfg_div_int  integer divisor
//     cfg_div_frac fractional divisor in units of 2^-FRAC_W
//     o_os_tick    oversample strobe, one per period
//     o_bit_tick   strobe when the oversample index wraps OS-1 -> 0
//     o_mid_tick   strobe when the oversample index goes OS/2-1 -> OS/2
//     o_os_phase   current oversample index
//     o_cfg_err    one-cycle pulse after a rejected config write
// All outputs are registered.
module uart_baud_gen #(
    parameter int unsigned INT_W        = 20,
    parameter int unsigned FRAC_W       = 8,
    parameter int unsigned OS           = 16,
    parameter int unsigned DEF_DIV_INT  = 651,
    parameter int unsigned DEF_DIV_FRAC = 11
) (
    input logic            clk,
    input logic            reset,
    uart_baud_gen_if.slave bus
);

    localparam int unsigned PH_W = (OS > 1) ? $clog2(OS) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OS / 2 - 1);

    logic [INT_W-1:0]  div_int_q, div_int_d;
    logic [FRAC_W-1:0] div_frac_q, div_frac_d;
    logic [INT_W-1:0]  sh_int_q, sh_int_d;
    logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
    logic              pend_q, pend_d;
    logic [INT_W-1:0]  cnt_q, cnt_d;
    logic [PH_W-1:0]   os_cnt_q, os_cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic              os_tick_q, os_tick_d;
    logic              bit_tick_q, bit_tick_d;
    logic              mid_tick_q, mid_tick_d;
    logic              cfg_err_q, cfg_err_d;

    logic [INT_W-1:0]  term;
    logic [FRAC_W:0]   frac_sum;
    logic              cfg_ok;
    logic              apply;

    // div_int >= 2 is guaranteed, so term never underflows.
    assign term     = div_int_q - INT_W'(1) + INT_W'(carry_q);
    assign frac_sum = {1'b0, acc_q} + {1'b0, div_frac_q};
    assign cfg_ok   = bus.cfg_we && (bus.cfg_div_int >= INT_W'(2));

    always_comb begin
        div_int_d  = div_int_q;
        div_frac_d = div_frac_q;
        sh_int_d   = sh_int_q;
        sh_frac_d  = sh_frac_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        os_cnt_d   = os_cnt_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        mid_tick_d = 1'b0;
        cfg_err_d  = bus.cfg_we && !cfg_ok;
        apply      = 1'b0;

        if (!bus.div_en) begin
            cnt_d    = '0;
            os_cnt_d = '0;
            acc_d    = '0;
            carry_d  = 1'b0;
            apply    = pend_q;
        end else if (bus.sync) begin
            // The sync cycle itself is cycle 0 of the new period, so the counter
            // resumes at 1; this puts the first mid tick (OS/2)*div_int after sync.
            cnt_d    = INT_W'(1);
            os_cnt_d = '0;
            acc_d    = '0;
            carry_d  = 1'b0;
            apply    = pend_q;
        end else if (cnt_q == term) begin
            cnt_d              = '0;
            os_cnt_d           = (os_cnt_q == PH_LAST) ? '0 : os_cnt_q + PH_W'(1);
            {carry_d, acc_d}   = frac_sum;
            os_tick_d          = 1'b1;
            bit_tick_d         = (os_cnt_q == PH_LAST);
            mid_tick_d         = (os_cnt_q == PH_MID);
            apply              = pend_q;
        end else begin
            cnt_d = cnt_q + INT_W'(1);
        end

        // A freshly applied divisor starts with a clean fractional phase.
        if (apply) begin
            div_int_d  = sh_int_q;
            div_frac_d = sh_frac_q;
            acc_d      = '0;
            carry_d    = 1'b0;
            pend_d     = 1'b0;
        end

        // Idle writes go straight to the active divisor; running writes wait in the
        // shadow, the latest one winning.
        if (cfg_ok) begin
            if (!bus.div_en) begin
                div_int_d  = bus.cfg_div_int;
                div_frac_d = bus.cfg_div_frac;
                pend_d     = 1'b0;
            end else begin
                sh_int_d  = bus.cfg_div_int;
                sh_frac_d = bus.cfg_div_frac;
                pend_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_int_q  <= INT_W'(DEF_DIV_INT);
            div_frac_q <= FRAC_W'(DEF_DIV_FRAC);
            sh_int_q   <= INT_W'(DEF_DIV_INT);
            sh_frac_q  <= FRAC_W'(DEF_DIV_FRAC);
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            os_cnt_q   <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
            mid_tick_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            div_int_q  <= div_int_d;
            div_frac_q <= div_frac_d;
            sh_int_q   <= sh_int_d;
            sh_frac_q  <= sh_frac_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            os_cnt_q   <= os_cnt_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
            mid_tick_q <= mid_tick_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign bus.o_os_tick  = os_tick_q;
    assign bus.o_bit_tick = bit_tick_q;
    assign bus.o_mid_tick = mid_tick_q;
    assign bus.o_os_phase = os_cnt_q;
    assign bus.o_cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed scenarios plus randomized control traffic, all checked
// cycle by cycle against a closed-form timing model of the tick generator.
module tb_uart_baud_gen;

    localparam int unsigned INT_W  = 20;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned OS     = 16;
    localparam int unsigned PH_W   = $clog2(OS);
    localparam int          DEF_INT  = 651;
    localparam int          DEF_FRAC = 11;

    logic clk = 1'b0;
    logic reset = 1'b0;

    uart_baud_gen_if #(.INT_W(INT_W), .FRAC_W(FRAC_W), .OS(OS)) bus ();

    uart_baud_gen #(
        .INT_W       (INT_W),
        .FRAC_W      (FRAC_W),
        .OS          (OS),
        .DEF_DIV_INT (DEF_INT),
        .DEF_DIV_FRAC(DEF_FRAC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Stimulus for the next edge; sync/we are one-shot.
    bit en_v = 0, sync_v = 0, we_v = 0;
    int ci_v = 0, cf_v = 0;

    // Reference model: within an epoch (started by enable, sync or a divisor change)
    // the n-th period end falls on edge B + n*div + floor((n-1)*frac/2^FRAC_W) - 1.
    bit m_run, m_pend;
    int m_b, m_m, m_nos, m_div, m_frac, m_sdiv, m_sfrac;
    logic [PH_W+3:0] exp_vec;

    int os_q[$];
    int first_mid, first_bit;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.o_os_tick, bus.o_bit_tick, bus.o_mid_tick, bus.o_cfg_err,
                    bus.o_os_phase});
    endfunction

    function automatic int q_at(input int i);
        if (i < os_q.size()) return os_q[i];
        return -1000000;
    endfunction

    task automatic model_reset();
        m_run = 0; m_pend = 0; m_b = 0; m_m = 0; m_nos = 0;
        m_div = DEF_INT; m_frac = DEF_FRAC; m_sdiv = 0; m_sfrac = 0;
        exp_vec = '0;
    endtask

    task automatic model_apply();
        m_div = m_sdiv; m_frac = m_sfrac; m_pend = 0;
    endtask

    task automatic model_edge();
        bit eos = 0, ebit = 0, emid = 0, eerr;
        int t;
        if (!en_v) begin
            m_run = 0; m_nos = 0;
            if (m_pend) model_apply();
        end else if (sync_v) begin
            m_run = 1; m_b = cyc; m_m = 0; m_nos = 0;
            if (m_pend) model_apply();
        end else begin
            if (!m_run) begin m_run = 1; m_b = cyc; m_m = 0; end
            t = m_b + (m_m + 1) * m_div + (m_m * m_frac) / (1 << FRAC_W) - 1;
            if (cyc == t) begin
                m_m++;
                m_nos = (m_nos + 1) % OS;
                eos = 1; ebit = (m_nos == 0); emid = (m_nos == OS / 2);
                if (m_pend) begin model_apply(); m_b = cyc + 1; m_m = 0; end
            end
        end
        eerr = we_v && (ci_v < 2);
        if (we_v && ci_v >= 2) begin
            if (!en_v) begin m_div = ci_v; m_frac = cf_v; m_pend = 0; end
            else begin m_sdiv = ci_v; m_sfrac = cf_v; m_pend = 1; end
        end
        exp_vec = {eos, ebit, emid, eerr, PH_W'(m_nos)};
    endtask

    // Called at a negedge: check this cycle's outputs, drive inputs, advance one cycle.
    task automatic step();
        check_eq("outs", outs(), 32'(exp_vec));
        if (bus.o_os_tick) os_q.push_back(cyc);
        if (bus.o_mid_tick && first_mid < 0) first_mid = cyc;
        if (bus.o_bit_tick && first_bit < 0) first_bit = cyc;
        bus.div_en       = en_v;
        bus.sync         = sync_v;
        bus.cfg_we       = we_v;
        bus.cfg_div_int  = INT_W'(ci_v);
        bus.cfg_div_frac = FRAC_W'(cf_v);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        sync_v = 0;
        we_v   = 0;
    endtask

    task automatic arm();
        os_q.delete();
        first_mid = -1;
        first_bit = -1;
    endtask

    task automatic cfg(input int di, input int df);
        we_v = 1; ci_v = di; cf_v = df;
        step();
    endtask

    initial begin
        int c0, s, n_long, n_bad, d;
        bus.div_en = 0; bus.sync = 0; bus.cfg_we = 0;
        bus.cfg_div_int = '0; bus.cfg_div_frac = '0;
        model_reset();

        // Outputs held low in reset.
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_outs", outs(), 32'd0);
        end
        reset = 1'b1;
        cyc = 0;

        // Defaults 651 + 11/256.
        en_v = 1; c0 = cyc; arm();
        for (int i = 0; i < 28000 && os_q.size() < 41; i++) step();
        check_eq("def_first_tick", 32'(q_at(0) - c0), 32'(DEF_INT));
        check_eq("def_first_bit", 32'(first_bit - c0), 32'(16 * DEF_INT));
        n_long = 0; n_bad = 0;
        for (int i = 1; i < 41; i++) begin
            d = q_at(i) - q_at(i - 1);
            if (d == DEF_INT + 1) n_long++;
            else if (d != DEF_INT) n_bad++;
        end
        check_eq("def_long_periods", 32'(n_long), 32'd1);
        check_eq("def_bad_periods", 32'(n_bad), 32'd0);

        // Integer divisor 4, written while idle.
        en_v = 0; step();
        cfg(4, 0); step();
        en_v = 1; c0 = cyc; arm();
        repeat (70) step();
        check_eq("int_tick1", 32'(q_at(0) - c0), 32'd4);
        check_eq("int_tick2", 32'(q_at(1) - c0), 32'd8);
        check_eq("int_mid", 32'(first_mid - c0), 32'd32);
        check_eq("int_bit", 32'(first_bit - c0), 32'd64);

        // Fractional 4 + 1/2.
        en_v = 0; step();
        cfg(4, 128);
        en_v = 1; c0 = cyc; arm();
        repeat (80) step();
        check_eq("frac_p1", 32'(q_at(0) - c0), 32'd4);
        check_eq("frac_p2", 32'(q_at(1) - q_at(0)), 32'd4);
        check_eq("frac_p3", 32'(q_at(2) - q_at(1)), 32'd5);
        check_eq("frac_p4", 32'(q_at(3) - q_at(2)), 32'd4);
        check_eq("frac_span16", 32'(q_at(16) - q_at(0)), 32'd72);

        // Resync mid-period at os index 11.
        en_v = 0; step();
        cfg(4, 0);
        en_v = 1; c0 = cyc;
        repeat (46) step();
        check_eq("pre_sync_phase", 32'(bus.o_os_phase), 32'd11);
        s = cyc; sync_v = 1; arm();
        step();
        check_eq("sync_no_tick", 32'(bus.o_os_tick), 32'd0);
        check_eq("sync_phase", 32'(bus.o_os_phase), 32'd0);
        repeat (40) step();
        check_eq("sync_mid", 32'(first_mid - s), 32'd32);
        check_eq("sync_tick1", 32'(q_at(0) - s), 32'd4);

        // Rejected write.
        cfg(1, 0);
        check_eq("cfg_err", 32'(bus.o_cfg_err), 32'd1);
        arm();
        repeat (12) step();
        check_eq("err_period", 32'(q_at(1) - q_at(0)), 32'd4);

        // Two writes mid-period; the last one takes over at the period end.
        sync_v = 1; s = cyc; step();
        cfg(6, 0);
        cfg(8, 0);
        arm();
        repeat (30) step();
        check_eq("wr_old_end", 32'(q_at(0) - s), 32'd4);
        check_eq("wr_new_period", 32'(q_at(1) - q_at(0)), 32'd8);

        // Reset with a shadow pending and the counters mid-period.
        cfg(5, 0);
        cfg(1, 0);
        check_eq("pre_rst_err", 32'(bus.o_cfg_err), 32'd1);
        check_eq("pre_rst_phase", 32'(bus.o_os_phase), 32'd4);
        reset = 1'b0;
        #1;
        check_eq("rst_async", outs(), 32'd0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            check_eq("rst_hold", outs(), 32'd0);
        end
        reset = 1'b1;
        model_reset();
        en_v = 1; c0 = cyc; arm();
        repeat (660) step();
        check_eq("rst_default_tick", 32'(q_at(0) - c0), 32'(DEF_INT));

        // Randomized control traffic with small divisors.
        en_v = 0; step();
        cfg(3, 0);
        en_v = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       en_v = 0;
                1, 2:    en_v = 1;
                3:       sync_v = 1;
                4, 5, 6: begin
                    we_v = 1; ci_v = $urandom_range(0, 7); cf_v = $urandom_range(0, 255);
                end
                default: ;
            endcase
            step();
            repeat ($urandom_range(1, 30)) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
